// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer: queues 128-bit plaintext blocks from the UART receiver, feeds them one at a
// time to the AES core, captures the ciphertext and hands it to the UART transmitter.
//
// Parameters:
//   DEPTH        input queue depth in blocks (power of 2, >= 2)
//   AES_TIMEOUT  cycles allowed from aes_start until the block is abandoned (>= 2)
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_valid, rx_data         block from receiver (one-cycle pulse)
//   aes_start, aes_data_in    start pulse and registered plaintext to AES core
//   aes_done, aes_result      completion pulse and ciphertext from AES core
//   tx_start, tx_data         start pulse and registered ciphertext to transmitter
//   tx_done                   transmitter completion pulse
//   clr_err                   clears overflow, err_timeout, drop_count
//   busy, fifo_count          status: FSM not idle, blocks queued
//   overflow, err_timeout     sticky error flags
//   drop_count, blocks_done   saturating drop counter, wrapping completion counter
module aes_block_sequencer #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned AES_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [127:0]           rx_data,
  output logic                   aes_start,
  output logic [127:0]           aes_data_in,
  input  logic                   aes_done,
  input  logic [127:0]           aes_result,
  output logic                   tx_start,
  output logic [127:0]           tx_data,
  input  logic                   tx_done,
  input  logic                   clr_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   err_timeout,
  output logic [7:0]             drop_count,
  output logic [15:0]            blocks_done
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(AES_TIMEOUT);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);
  // The ISSUE cycle counts toward the budget, so AES_WAIT lasts AES_TIMEOUT-1 cycles.
  localparam logic [TmrW-1:0] TmrLast = TmrW'(AES_TIMEOUT - 2);

  typedef enum logic [2:0] {StIdle, StIssue, StAesWait, StTxIssue, StTxWait} state_e;

  state_e state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;

  logic [127:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [127:0]    aes_data_q, tx_data_q;
  logic            overflow_q, err_timeout_q;
  logic [7:0]      drop_count_q;
  logic [15:0]     blocks_done_q;

  logic load_pt, pop, capture_ct, timeout, tx_fin;
  logic full, push, drop;

  assign full = (count_q == Full);
  assign push = rx_valid && (!full || pop);
  assign drop = rx_valid && full && !pop;

  // Next-state and Moore strobes.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    load_pt    = 1'b0;
    pop        = 1'b0;
    capture_ct = 1'b0;
    timeout    = 1'b0;
    tx_fin     = 1'b0;
    aes_start  = 1'b0;
    tx_start   = 1'b0;
    case (state_q)
      StIdle: begin
        // Head is latched here so aes_data_in is already valid while aes_start is high.
        if (count_q != '0) begin
          load_pt = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        aes_start = 1'b1;
        pop       = 1'b1;
        tmr_d     = '0;
        state_d   = StAesWait;
      end
      StAesWait: begin
        if (aes_done) begin
          capture_ct = 1'b1;
          state_d    = StTxIssue;
        end else if (tmr_q == TmrLast) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StTxIssue: begin
        tx_start = 1'b1;
        state_d  = StTxWait;
      end
      StTxWait: begin
        if (tx_done) begin
          tx_fin  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Storage needs no reset: it is only read when count_q says the slot holds a block.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      aes_data_q    <= '0;
      tx_data_q     <= '0;
      overflow_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      drop_count_q  <= '0;
      blocks_done_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      if (load_pt) begin
        aes_data_q <= mem_q[rd_ptr_q];
      end
      if (capture_ct) begin
        tx_data_q <= aes_result;
      end
      if (tx_fin) begin
        blocks_done_q <= blocks_done_q + 16'd1;
      end
      // Clear takes priority over a same-cycle drop or timeout.
      if (clr_err) begin
        overflow_q    <= 1'b0;
        err_timeout_q <= 1'b0;
        drop_count_q  <= '0;
      end else begin
        if (timeout) begin
          err_timeout_q <= 1'b1;
        end
        if (drop) begin
          overflow_q <= 1'b1;
          if (drop_count_q != 8'hFF) begin
            drop_count_q <= drop_count_q + 8'd1;
          end
        end
      end
    end
  end

  assign busy        = (state_q != StIdle);
  assign fifo_count  = count_q;
  assign aes_data_in = aes_data_q;
  assign tx_data     = tx_data_q;
  assign overflow    = overflow_q;
  assign err_timeout = err_timeout_q;
  assign drop_count  = drop_count_q;
  assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Testbench for aes_block_sequencer: table-driven single-block vectors plus hand-written
// sequences for backpressure, timeout, saturation, reset and spurious pulses. A small AES/TX
// responder model inside step() answers the DUT and checks issue/transmit order via queues.
module tb_aes_block_sequencer;
  localparam int unsigned DEPTH       = 2;
  localparam int unsigned AES_TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   rst, rx_valid, aes_done, tx_done, clr_err;
  logic [127:0]           rx_data, aes_result;
  logic                   aes_start, tx_start, busy, overflow, err_timeout;
  logic [127:0]           aes_data_in, tx_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0]             drop_count;
  logic [15:0]            blocks_done;

  aes_block_sequencer #(
    .DEPTH       (DEPTH),
    .AES_TIMEOUT (AES_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .aes_start   (aes_start),
    .aes_data_in (aes_data_in),
    .aes_done    (aes_done),
    .aes_result  (aes_result),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .clr_err     (clr_err),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .err_timeout (err_timeout),
    .drop_count  (drop_count),
    .blocks_done (blocks_done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FipsPt = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsCt = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic [127:0] pt;
    logic [127:0] ct;
    logic [7:0]   aes_lat;
    logic [7:0]   tx_lat;
  } vec_t;

  vec_t vecs [4];

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: plaintexts expected at aes_start, AES responses, ciphertexts expected at tx_start.
  logic [127:0] pt_q [$];
  logic [127:0] res_q [$];
  logic [127:0] ct_q [$];
  logic [127:0] cur_ct = '0;
  int aes_cnt = 0, tx_cnt = 0, aes_lat = 4, tx_lat = 2, exp_blocks = 0;
  bit aes_hang = 1'b0, tx_hang = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock, sample DUT, then drive next-cycle inputs (pulses default low).
  task automatic step();
    logic [127:0] e;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    aes_done = 1'b0;
    tx_done  = 1'b0;
    clr_err  = 1'b0;
    rst      = 1'b0;
    if (aes_cnt > 0) begin
      aes_cnt--;
      if (aes_cnt == 0) begin
        aes_done   = 1'b1;
        aes_result = cur_ct;
        ct_q.push_back(cur_ct);
      end
    end
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        exp_blocks++;
      end
    end
    if (aes_start) begin
      if (pt_q.size() == 0) begin
        n_checks++;
        $display("FAIL aes_start: got pulse expected no block pending");
      end else begin
        e = pt_q.pop_front();
        chk("aes_data_in order", aes_data_in, e);
        cur_ct = res_q.pop_front();
        if (!aes_hang) aes_cnt = aes_lat;
      end
    end
    if (tx_start) begin
      if (ct_q.size() == 0) begin
        n_checks++;
        $display("FAIL tx_start: got pulse expected no ciphertext pending");
      end else begin
        e = ct_q.pop_front();
        chk("tx_data order", tx_data, e);
        if (!tx_hang) tx_cnt = tx_lat;
      end
    end
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] ct, input bit accept);
    rx_valid = 1'b1;
    rx_data  = pt;
    if (accept) begin
      pt_q.push_back(pt);
      res_q.push_back(ct);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    repeat (3) step();
    while ((busy || fifo_count != 0) && n < 400) begin
      step();
      n++;
    end
    chk({name, " idle"}, 128'({busy, fifo_count != 0}), 128'(0));
    chk({name, " scoreboard empty"}, 128'(pt_q.size() + ct_q.size()), 128'(0));
    chk({name, " blocks_done"}, 128'(blocks_done), 128'(exp_blocks[15:0]));
  endtask

  task automatic chk_reset(input string name);
    chk({name, " fifo_count"}, 128'(fifo_count), 128'(0));
    chk({name, " strobes/busy/flags"},
        128'({aes_start, tx_start, busy, overflow, err_timeout}), 128'(0));
    chk({name, " drop_count"}, 128'(drop_count), 128'(0));
    chk({name, " blocks_done"}, 128'(blocks_done), 128'(0));
    chk({name, " aes_data_in"}, aes_data_in, 128'(0));
    chk({name, " tx_data"}, tx_data, 128'(0));
  endtask

  initial begin
    vecs[0] = '{pt: 128'h0123456789abcdef_fedcba9876543210,
                ct: 128'hdeadbeef_00000001_cafef00d_12345678, aes_lat: 8'd1, tx_lat: 8'd1};
    vecs[1] = '{pt: 128'hffffffff_ffffffff_ffffffff_ffffffff,
                ct: 128'h00000000_00000000_00000000_00000001, aes_lat: 8'd2, tx_lat: 8'd5};
    vecs[2] = '{pt: 128'h00000000_00000000_00000000_00000000,
                ct: 128'h80000000_00000000_00000000_00000000, aes_lat: 8'd62, tx_lat: 8'd2};
    // aes_done in the very last AES_WAIT cycle must win over the timeout.
    vecs[3] = '{pt: 128'ha5a5a5a5_5a5a5a5a_3c3c3c3c_c3c3c3c3,
                ct: 128'h0f0f0f0f_f0f0f0f0_11223344_55667788, aes_lat: 8'd63, tx_lat: 8'd3};

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; aes_done = 1'b0; aes_result = '0;
    tx_done = 1'b0; clr_err = 1'b0;
    step();
    chk_reset("reset");

    // Single block with exact cycle timing (cycle 0 = rx_valid).
    aes_lat = 11; tx_lat = 3;
    send(FipsPt, FipsCt, 1'b1);
    step();
    chk("single fifo_count c1", 128'(fifo_count), 128'(1));
    chk("single aes_start c1", 128'(aes_start), 128'(0));
    step();
    chk("single aes_start c2", 128'(aes_start), 128'(1));
    chk("single aes_data_in c2", aes_data_in, FipsPt);
    repeat (11) step();
    chk("single tx_start before done", 128'(tx_start), 128'(0));
    step();
    chk("single tx_start N+1", 128'(tx_start), 128'(1));
    chk("single tx_data", tx_data, FipsCt);
    step();
    chk("single tx_start one cycle", 128'(tx_start), 128'(0));
    chk("single busy in TX_WAIT", 128'(busy), 128'(1));
    repeat (3) step();
    chk("single blocks_done", 128'(blocks_done), 128'(1));
    chk("single busy after", 128'(busy), 128'(0));

    for (int i = 0; i < 4; i++) begin
      aes_lat = int'(vecs[i].aes_lat);
      tx_lat  = int'(vecs[i].tx_lat);
      send(vecs[i].pt, vecs[i].ct, 1'b1);
      step();
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d aes_data_in held", i), aes_data_in, vecs[i].pt);
    end

    // Backpressure with full+pop: A issued, B queued, C accepted on the ISSUE pop, D dropped.
    aes_lat = 30; tx_lat = 2;
    send(128'hA, 128'hCA, 1'b1); step();
    send(128'hB, 128'hCB, 1'b1); step();
    chk("bp fifo_count full at issue", 128'(fifo_count), 128'(2));
    chk("bp aes_start", 128'(aes_start), 128'(1));
    send(128'hC, 128'hCC, 1'b1); step();
    chk("fullpop fifo_count", 128'(fifo_count), 128'(2));
    chk("fullpop no overflow", 128'(overflow), 128'(0));
    send(128'hD, 128'hCD, 1'b0); step();
    chk("bp overflow", 128'(overflow), 128'(1));
    chk("bp drop_count", 128'(drop_count), 128'(1));
    chk("bp fifo_count after drop", 128'(fifo_count), 128'(2));
    drain("bp");
    chk("bp overflow sticky", 128'(overflow), 128'(1));
    clr_err = 1'b1; step();
    chk("bp clr flags", 128'({overflow, drop_count}), 128'(0));

    // Spurious completion pulses.
    aes_done = 1'b1; aes_result = 128'h1234; step();
    chk("spurious aes_done idle", 128'({busy, fifo_count}), 128'(0));
    chk("spurious aes_done blocks", 128'(blocks_done), 128'(exp_blocks[15:0]));
    aes_lat = 8; tx_lat = 2;
    send(128'hE, 128'hCE, 1'b1);
    repeat (4) step();
    tx_done = 1'b1; step();
    chk("spurious tx_done busy", 128'(busy), 128'(1));
    chk("spurious tx_done no tx_start", 128'(tx_start), 128'(0));
    chk("spurious tx_done blocks", 128'(blocks_done), 128'(exp_blocks[15:0]));
    drain("spurious");

    // Timeout: X hangs, Y follows once the abort returns the FSM to IDLE.
    aes_hang = 1'b1; aes_lat = 4; tx_lat = 2;
    send(128'h1111, 128'hC111, 1'b1); step();
    send(128'h2222, 128'hC222, 1'b1); step();
    chk("to aes_start S", 128'(aes_start), 128'(1));
    repeat (63) step();
    chk("to no err at S+63", 128'({err_timeout, busy}), 128'(1));
    aes_hang = 1'b0;
    step();
    chk("to err at S+64", 128'(err_timeout), 128'(1));
    chk("to idle at S+64", 128'(busy), 128'(0));
    step();
    chk("to next issued", 128'(aes_start), 128'(1));
    drain("timeout");
    chk("to err sticky", 128'(err_timeout), 128'(1));
    clr_err = 1'b1; step();
    chk("to clr", 128'(err_timeout), 128'(0));

    // Stuck transmitter: queue stays full so every rx_valid is dropped.
    aes_lat = 2; tx_hang = 1'b1;
    send(128'h5550, 128'hC550, 1'b1); step();
    send(128'h5551, 128'hC551, 1'b1); step();
    send(128'h5552, 128'hC552, 1'b1); step();
    repeat (10) step();
    chk("sat fifo_count", 128'(fifo_count), 128'(2));
    chk("sat busy", 128'({busy, tx_start}), 128'(2));
    for (int i = 0; i < 254; i++) begin
      send(128'(i), '0, 1'b0);
      step();
    end
    chk("sat drop_count 254", 128'(drop_count), 128'(254));
    for (int i = 0; i < 46; i++) begin
      send(128'(i), '0, 1'b0);
      step();
    end
    chk("sat drop_count 255", 128'(drop_count), 128'(255));
    chk("sat overflow", 128'(overflow), 128'(1));
    send(128'h77, '0, 1'b0); clr_err = 1'b1; step();
    chk("clr beats drop", 128'({overflow, drop_count}), 128'(0));
    send(128'h78, '0, 1'b0); step();
    chk("drop after clr", 128'(drop_count), 128'(1));

    // Reset in TX_WAIT with two blocks queued.
    pt_q.delete(); res_q.delete(); ct_q.delete();
    aes_cnt = 0; tx_cnt = 0; tx_hang = 1'b0; exp_blocks = 0;
    rst = 1'b1; step();
    chk_reset("midreset");
    tx_done = 1'b1; step();
    aes_done = 1'b1; step();
    step();
    chk("midreset late tx_done ignored", 128'(blocks_done), 128'(0));
    chk("midreset stays idle", 128'({busy, tx_start, aes_start, fifo_count}), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
